// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that serialises 1- or 2-byte producer frames into an async FIFO write port.
// Define FRAME_HDR_EN to prefix every frame with a header byte {4'hA, len, id[2:0]}.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_len,
  output logic [NUM_REQ-1:0]              ack,
  input  logic                            fifo_full,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic                            fifo_wr_inc,
  output logic                            busy
);

  localparam int PW = 2 * DATA_WIDTH;

`ifdef FRAME_HDR_EN
  typedef enum logic [2:0] {IDLE, HDR, LO, HI, ACK} state_t;
`else
  typedef enum logic [2:0] {IDLE, LO, HI, ACK} state_t;
`endif

  state_t                  state;
  logic [DATA_WIDTH-1:0]   hi_byte;
  logic                    frame_len;
  logic [ID_WIDTH-1:0]     grant;
  logic [ID_WIDTH-1:0]     last_grant;
  logic [ID_WIDTH-1:0]     next_id;
  logic                    req_found;

`ifdef FRAME_HDR_EN
  logic [DATA_WIDTH-1:0]   lo_byte;

  function automatic logic [DATA_WIDTH-1:0] hdr_byte(input logic [ID_WIDTH-1:0] id, input logic len);
    logic [7:0] h;
    h = {4'hA, len, 3'(id)};
    return DATA_WIDTH'(h);
  endfunction
`endif

  // Search starts just past the last grant, so a freshly served requester ranks last.
  always_comb begin
    req_found = 1'b0;
    next_id   = last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!req_found && req[(int'(last_grant) + i) % NUM_REQ]) begin
        req_found = 1'b1;
        next_id   = ID_WIDTH'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef FRAME_HDR_EN
  assign fifo_wr_inc = (state == HDR || state == LO || state == HI) && !fifo_full;
`else
  assign fifo_wr_inc = (state == LO || state == HI) && !fifo_full;
`endif

  // fifo_wr_data always holds the byte for the current state; it only advances on a real write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ack          <= '0;
      fifo_wr_data <= '0;
      hi_byte      <= '0;
      frame_len    <= 1'b0;
      grant        <= '0;
      last_grant   <= ID_WIDTH'(NUM_REQ - 1);
`ifdef FRAME_HDR_EN
      lo_byte      <= '0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (req_found) begin
            hi_byte    <= req_data[int'(next_id)*PW + DATA_WIDTH +: DATA_WIDTH];
            frame_len  <= req_len[next_id];
            grant      <= next_id;
            last_grant <= next_id;
`ifdef FRAME_HDR_EN
            lo_byte      <= req_data[int'(next_id)*PW +: DATA_WIDTH];
            fifo_wr_data <= hdr_byte(next_id, req_len[next_id]);
            state        <= HDR;
`else
            fifo_wr_data <= req_data[int'(next_id)*PW +: DATA_WIDTH];
            state        <= LO;
`endif
          end
        end
`ifdef FRAME_HDR_EN
        HDR: begin
          if (!fifo_full) begin
            fifo_wr_data <= lo_byte;
            state        <= LO;
          end
        end
`endif
        LO: begin
          if (!fifo_full) begin
            if (frame_len) begin
              fifo_wr_data <= hi_byte;
              state        <= HI;
            end else begin
              ack[grant] <= 1'b1;
              state      <= ACK;
            end
          end
        end
        HI: begin
          if (!fifo_full) begin
            ack[grant] <= 1'b1;
            state      <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
